// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR envelope core.
package adsr_pkg;

  localparam int unsigned ACC_W  = 24;
  localparam int unsigned FRAC_W = 8;

  localparam logic [ACC_W-1:0] LMAX = ACC_W'(32'd32767 << FRAC_W);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  // Negative control voltages clamp to zero.
  function automatic logic [14:0] cv_pos(input logic signed [15:0] cv);
    return cv[15] ? '0 : cv[14:0];
  endfunction

endpackage

// File: rtl/sample_tick.sv
// Brings an asynchronous sample clock into the clk domain as a 1-cycle tick.
module sample_tick (
  input  logic clk,
  input  logic rst,
  input  logic sample_clk,
  output logic tick
);

  logic sync1, sync2, prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      tick  <= 1'b0;
    end else begin
      sync1 <= sample_clk;
      sync2 <= sync1;
      prev  <= sync2;
      tick  <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// Gate-driven ADSR envelope generator; state advances once per audio sample tick.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter logic signed [15:0] GATE_HI   = 16'sd4000,
  parameter logic signed [15:0] GATE_LO   = 16'sd2000,
  parameter logic signed [15:0] EOC_LEVEL = 16'sd16384
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_clk,
  input  logic signed [15:0] sample_in0,
  input  logic signed [15:0] sample_in1,
  input  logic signed [15:0] sample_in2,
  input  logic signed [15:0] sample_in3,
  output logic signed [15:0] sample_out0,
  output logic signed [15:0] sample_out1,
  output logic signed [15:0] sample_out2,
  output logic signed [15:0] sample_out3
);

  logic tick;

  sample_tick u_tick (
    .clk        (clk),
    .rst        (rst),
    .sample_clk (sample_clk),
    .tick       (tick)
  );

  env_state_t        state_q, state_n;
  logic [ACC_W-1:0]  l_q, l_n;
  logic              gate_q, gate_n;
  logic              eoc_n;

  logic [16:0]         step_a, step_r;
  logic [ACC_W-1:0]    sus_l;
  logic [ACC_W:0]      att_sum;
  logic                att_full;
  logic signed [ACC_W:0] rel_diff;
  logic                rel_done, dec_done;
  env_state_t          rel_st;
  logic [ACC_W-1:0]    rel_l;

  always_comb begin
    step_a   = {2'b00, cv_pos(sample_in1)} + 17'd1;
    step_r   = {2'b00, cv_pos(sample_in2)} + 17'd1;
    sus_l    = {1'b0, cv_pos(sample_in3), 8'h00};
    att_sum  = {1'b0, l_q} + {8'h00, step_a};
    att_full = att_sum >= {1'b0, LMAX};
    rel_diff = $signed({1'b0, l_q}) - $signed({8'h00, step_r});
    rel_done = rel_diff <= 25'sd0;
    dec_done = rel_diff <= $signed({1'b0, sus_l});
    // Release may complete on the very tick the gate drops, from any stage.
    rel_st   = rel_done ? IDLE : RELEASE;
    rel_l    = rel_done ? '0 : rel_diff[ACC_W-1:0];
  end

  always_comb begin
    gate_n = gate_q;
    if (sample_in0 > GATE_HI)      gate_n = 1'b1;
    else if (sample_in0 < GATE_LO) gate_n = 1'b0;

    state_n = state_q;
    l_n     = l_q;
    eoc_n   = 1'b0;
    case (state_q)
      IDLE: begin
        l_n = '0;
        if (gate_n) begin
          state_n = ATTACK;
          l_n     = att_sum[ACC_W-1:0];
        end
      end
      ATTACK: begin
        if (!gate_n) begin
          state_n = rel_st; l_n = rel_l; eoc_n = rel_done;
        end else if (att_full) begin
          state_n = DECAY; l_n = LMAX;
        end else begin
          l_n = att_sum[ACC_W-1:0];
        end
      end
      DECAY: begin
        if (!gate_n) begin
          state_n = rel_st; l_n = rel_l; eoc_n = rel_done;
        end else if (dec_done) begin
          state_n = SUSTAIN; l_n = sus_l;
        end else begin
          l_n = rel_diff[ACC_W-1:0];
        end
      end
      SUSTAIN: begin
        if (!gate_n) begin
          state_n = rel_st; l_n = rel_l; eoc_n = rel_done;
        end else begin
          l_n = sus_l;
        end
      end
      RELEASE: begin
        if (gate_n) begin
          state_n = ATTACK;
          l_n     = att_full ? LMAX : att_sum[ACC_W-1:0];
        end else begin
          state_n = rel_st; l_n = rel_l; eoc_n = rel_done;
        end
      end
      default: begin
        state_n = IDLE;
        l_n     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      l_q         <= '0;
      gate_q      <= 1'b0;
      sample_out0 <= '0;
      sample_out1 <= '0;
      sample_out2 <= '0;
      sample_out3 <= '0;
    end else if (tick) begin
      state_q     <= state_n;
      l_q         <= l_n;
      gate_q      <= gate_n;
      sample_out0 <= $signed(l_n[ACC_W-1:FRAC_W]);
      sample_out1 <= gate_n ? EOC_LEVEL : '0;
      sample_out2 <= 16'sd32767 - $signed(l_n[ACC_W-1:FRAC_W]);
      sample_out3 <= eoc_n ? EOC_LEVEL : '0;
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: reference model with scoreboard plus directed corner cases.
module tb_adsr_envelope;
  import adsr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sample_clk = 1'b0;
  logic signed [15:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic signed [15:0] out0, out1, out2, out3;

  adsr_envelope #(
    .GATE_HI   (16'sd4000),
    .GATE_LO   (16'sd2000),
    .EOC_LEVEL (16'sd16384)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_clk  (sample_clk),
    .sample_in0  (in0),
    .sample_in1  (in1),
    .sample_in2  (in2),
    .sample_in3  (in3),
    .sample_out0 (out0),
    .sample_out1 (out1),
    .sample_out2 (out2),
    .sample_out3 (out3)
  );

  always #5 clk = ~clk;

  typedef struct { int o0; int o1; int o2; int o3; } exp_t;
  typedef struct { int g; int a1; int a2; int a3; int e0; int e1; int e3; int est; } vec_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int last_o0 = 0;

  localparam int LMAX_I = 32767 * 256;
  int m_st, m_l, m_gate;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_l = 0; m_gate = 0; last_o0 = 0;
    sb.delete();
  endtask

  task automatic model_step(input int g, input int a1, input int a2, input int a3);
    int a, r, s, eoc, do_rel;
    exp_t e;
    if (g > 4000) m_gate = 1;
    else if (g < 2000) m_gate = 0;
    a = (a1 > 0 ? a1 : 0) + 1;
    r = (a2 > 0 ? a2 : 0) + 1;
    s = (a3 > 0 ? a3 : 0) * 256;
    eoc = 0; do_rel = 0;
    if (!m_gate && m_st >= 1 && m_st <= 3) do_rel = 1;
    else case (m_st)
      0: if (m_gate) begin m_st = 1; m_l = a; end else m_l = 0;
      1: begin m_l += a; if (m_l >= LMAX_I) begin m_l = LMAX_I; m_st = 2; end end
      2: begin m_l -= r; if (m_l <= s) begin m_l = s; m_st = 3; end end
      3: m_l = s;
      default: if (m_gate) begin
                 m_st = 1; m_l += a; if (m_l > LMAX_I) m_l = LMAX_I;
               end else do_rel = 1;
    endcase
    if (do_rel) begin
      m_l -= r;
      if (m_l <= 0) begin m_l = 0; m_st = 0; eoc = 1; end
      else m_st = 4;
    end
    e.o0 = m_l / 256;
    e.o1 = m_gate ? 16384 : 0;
    e.o2 = 32767 - e.o0;
    e.o3 = eoc ? 16384 : 0;
    sb.push_back(e);
  endtask

  task automatic do_tick(input int g, input int a1, input int a2, input int a3);
    exp_t e;
    @(posedge clk); #1;
    in0 = 16'(g); in1 = 16'(a1); in2 = 16'(a2); in3 = 16'(a3);
    sample_clk = 1'b1;
    model_step(g, a1, a2, a3);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    chk("hold_out0", int'(out0), last_o0);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("sb_out0", int'(out0), e.o0);
    chk("sb_out1", int'(out1), e.o1);
    chk("sb_out2", int'(out2), e.o2);
    chk("sb_out3", int'(out3), e.o3);
    last_o0 = e.o0;
    sample_clk = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic run(input int n, input int g, input int a1, input int a2, input int a3);
    repeat (n) do_tick(g, a1, a2, a3);
  endtask

  task automatic reset_all();
    @(posedge clk); #2;
    rst = 1'b1;
    sample_clk = 1'b0;
    #1;
    chk("rst_out0", int'(out0), 0);
    chk("rst_out1", int'(out1), 0);
    chk("rst_out2", int'(out2), 0);
    chk("rst_out3", int'(out3), 0);
    chk("rst_state", int'(dut.state_q), int'(IDLE));
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
  endtask

  vec_t tbl[5];
  int nt;

  initial begin
    tbl[0] = '{g:0,    a1:32767, a2:255, a3:0, e0:0,   e1:0,     e3:0, est:0};
    tbl[1] = '{g:3000, a1:32767, a2:255, a3:0, e0:0,   e1:0,     e3:0, est:0};
    tbl[2] = '{g:4001, a1:32767, a2:255, a3:0, e0:128, e1:16384, e3:0, est:1};
    tbl[3] = '{g:2500, a1:32767, a2:255, a3:0, e0:256, e1:16384, e3:0, est:1};
    tbl[4] = '{g:1999, a1:32767, a2:255, a3:0, e0:255, e1:0,     e3:0, est:4};

    reset_all();

    // Hysteresis table
    for (int i = 0; i < 5; i++) begin
      do_tick(tbl[i].g, tbl[i].a1, tbl[i].a2, tbl[i].a3);
      chk("hyst_out0", int'(out0), tbl[i].e0);
      chk("hyst_out1", int'(out1), tbl[i].e1);
      chk("hyst_out3", int'(out3), tbl[i].e3);
      chk("hyst_state", int'(dut.state_q), tbl[i].est);
    end

    // Full cycle
    reset_all();
    run(255, 8000, 32767, 32767, 16384);
    chk("full_attack_255", int'(out0), 32640);
    run(1, 8000, 32767, 32767, 16384);
    chk("full_attack_peak", int'(out0), 32767);
    chk("full_state_decay", int'(dut.state_q), int'(DECAY));
    run(128, 8000, 32767, 32767, 16384);
    chk("full_sustain", int'(out0), 16384);
    chk("full_state_sustain", int'(dut.state_q), int'(SUSTAIN));
    run(3, 8000, 32767, 32767, 16384);
    chk("full_sustain_hold", int'(out0), 16384);
    run(127, 0, 32767, 32767, 16384);
    chk("full_release_127", int'(out0), 128);
    chk("full_no_early_eoc", int'(out3), 0);
    run(1, 0, 32767, 32767, 16384);
    chk("full_release_end", int'(out0), 0);
    chk("full_eoc", int'(out3), 16384);
    chk("full_state_idle", int'(dut.state_q), int'(IDLE));
    run(1, 0, 32767, 32767, 16384);
    chk("full_eoc_one_tick", int'(out3), 0);

    // Re-trigger during release
    reset_all();
    run(256, 8000, 32767, 32767, 20000);
    run(100, 8000, 32767, 32767, 20000);
    chk("retrig_sustain", int'(out0), 20000);
    run(10, 0, 32767, 255, 20000);
    chk("retrig_released", int'(out0), 19990);
    chk("retrig_state_rel", int'(dut.state_q), int'(RELEASE));
    run(1, 8000, -1, 255, 20000);
    chk("retrig_resume", int'(out0), 19990);
    chk("retrig_state_att", int'(dut.state_q), int'(ATTACK));
    chk("retrig_no_eoc", int'(out3), 0);

    // Attack-rate clamp
    reset_all();
    run(255, 8000, -5000, 0, 0);
    chk("clamp_att_255", int'(out0), 0);
    run(1, 8000, -5000, 0, 0);
    chk("clamp_att_256", int'(out0), 1);

    // Sustain clamp
    reset_all();
    run(256, 8000, 32767, 32767, -1);
    run(255, 8000, 32767, 32767, -1);
    chk("clamp_sus_255", int'(out0), 127);
    run(1, 8000, 32767, 32767, -1);
    chk("clamp_sus_zero", int'(out0), 0);
    chk("clamp_sus_state", int'(dut.state_q), int'(SUSTAIN));
    chk("clamp_sus_no_eoc", int'(out3), 0);

    // Gate drop on the tick attack would peak
    reset_all();
    run(255, 8000, 32767, 32767, 0);
    run(1, 0, 32767, 32767, 0);
    chk("simul_state", int'(dut.state_q), int'(RELEASE));
    chk("simul_out0", int'(out0), 32512);
    chk("simul_out2", int'(out2), 255);

    // Reset mid-attack, then no spurious tick
    reset_all();
    run(78, 8000, 32767, 32767, 16384);
    chk("pre_reset_level", int'(out0), 9984);
    reset_all();
    nt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      nt += int'(dut.tick);
    end
    chk("no_tick_after_reset", nt, 0);
    chk("post_reset_out0", int'(out0), 0);
    run(1, 8000, 32767, 32767, 16384);
    chk("post_reset_restart", int'(out0), 128);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
